multicycle_processor: RTL and testbench
=======================================

// Module: multicycle_processor
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle core: FETCH/EXEC/MEM/HALT FSM.
//  Talks to instruction and data memories over req/ack handshakes, so memories may stall.
//  Configurable datapath width, register count and address width; adds a HALT instruction
//  and a per-instruction retire strobe. Same 32-bit instruction format, op/arg fields.
// PARAMETERS
//  DATA_W    32  datapath / register / data-memory word width (>=24)
//  NUM_REGS  16  architectural registers (2..16); index = low clog2(NUM_REGS) bits of 4-bit field
//  ADDR_W    32  instruction and data address width; PC is ADDR_W bits
//  RESET_PC   0  PC value loaded on reset
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  imem_req     out  1       instruction fetch request, held until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= PC)
//  imem_ack     in   1       fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32      instruction word
//  dmem_req     out  1       data access request, held until dmem_ack
//  dmem_we      out  1       1 = store, 0 = load; valid while dmem_req
//  dmem_addr    out  ADDR_W  data address
//  dmem_wdata   out  DATA_W  store data
//  dmem_ack     in   1       access complete; dmem_rdata valid this cycle for loads
//  dmem_rdata   in   DATA_W  load data
//  retire       out  1       one-cycle pulse when an instruction completes
//  halted       out  1       core is in HALT
// BEHAVIOUR
//  Fields: op=ins[31:30] arg=ins[29:28] f=ins[27:24] b2=ins[19:16] b3=ins[11:8] b4=ins[3:0];
//   imm = zero-extend/truncate ins[23:0] to DATA_W (and to ADDR_W for addresses).
//  op00 MOVE: arg00 R[f]<=dmem[R[b2]]; 01 R[f]<=imm; 10 dmem[R[b2]]<=R[f]; 11 R[f]<=R[b2].
//  op01 HALT (arg/fields ignored).
//  op10 JUMP: cond arg 00 always,01 Z,10 !Z,11 N; target = f[0] ? imm : R[b2]; else PC+1.
//  op11 ALU: R[b2] <= R[b3] op (R[b4] << f); arg 00 ADD,01 SUB,10 AND,11 OR; mod 2^DATA_W.
//   Z=(result==0), N=result[DATA_W-1] updated only by ALU ops; all other ops hold flags.
//  FSM: FETCH: imem_req=1, imem_addr=PC; on imem_ack latch IR, ->EXEC (ack allowed 1st cycle).
//   EXEC: decode IR. Load/store ->MEM. HALT ->HALT. Else write reg/flags, update PC,
//   retire=1, ->FETCH.
//   MEM: dmem_req=1, addr=R[b2] truncated, wdata=R[f] (stores), captured in EXEC and held
//   stable; on dmem_ack: load writes R[f], PC<=PC+1, retire=1, ->FETCH.
//   HALT: halted=1, no requests; exit only via reset. HALT itself does not retire.
//  Latency: ALU/move/jump 2 cycles min; load/store 3 min; each ack-wait cycle adds one.
//  PC+1 and jump targets wrap modulo 2^ADDR_W. Register reads in EXEC see prior writes.
//  req signals decoded from state only; never depend combinationally on ack.
//  Ack with req low is ignored. imem_rdata/dmem_rdata ignored except on their ack.
//  Reset (async, any state, incl. mid-handshake): PC=RESET_PC, Z=N=0, all regs 0,
//   state FETCH, IR 0; retire, halted, dmem_req, dmem_we low; imem_req asserts
//   on first cycle after release; abandoned transaction is not resumed.
// TESTING
//  T1 imm 5->R1, imm 7->R2, ADD R3=R1+R2, fetch ack 1st cycle -> R3=12, Z=0, retire every 2 cycles.
//  T2 R1=5,R2=5 SUB R3 then JUMP Z to imm 0x40 -> imem_addr=0x40 next fetch; JUMP !Z falls to PC+1.
//  T3 store R4=0xDEAD to addr R5=0x10, dmem_ack held low 3 cycles -> req/we/addr/wdata stable 4 cycles, 1 retire.
//  T4 load from 0x10 returns 0xDEAD into R6; ADD of 0xFFFFFFFF+1 (DATA_W=32) -> 0, Z=1, N=0.
//  T5 HALT at PC 3 -> halted=1, no further req for 20 cycles; reset low 1 cycle -> PC=RESET_PC, fetch resumes.
//  T6 DATA_W=24,NUM_REGS=4,ADDR_W=8: PC 0xFF wraps to 0x00; field 4'hD selects R1; mid-fetch reset drops imem_req.

Source files
------------

// File: rtl/multicycle_processor_if.sv
// Instruction- and data-memory req/ack bus of the multi-cycle core.
// The core drives the master side; memories or bench models use the slave side.
interface multicycle_processor_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle FETCH/EXEC/MEM/HALT core with req/ack instruction and data memories.
// Registered retire pulse per completed instruction; HALT is left only through reset.
module multicycle_processor #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 16,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_processor_if.master bus,
    output logic                   retire,
    output logic                   halted
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;
    typedef logic [DATA_W-1:0] word_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    word_t             regs_q [NUM_REGS];
    word_t             regs_d [NUM_REGS];
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              retire_q, retire_d;
    logic              halted_q, halted_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    word_t             wdata_q, wdata_d;

    logic [1:0]        op, arg;
    logic [3:0]        sh;
    logic [RW-1:0]     fi, b2i, b3i, b4i;
    word_t             imm_w, rf, rb2, rb3, rb4, opnd, alu_res;
    logic [ADDR_W-1:0] imm_a, pc_inc;
    logic              taken;

    logic              wr_en;
    logic [RW-1:0]     wr_idx;
    word_t             wr_val;

    // Field decode and register reads; indices beyond NUM_REGS read as zero.
    always_comb begin
        op     = ir_q[31:30];
        arg    = ir_q[29:28];
        sh     = ir_q[27:24];
        fi     = ir_q[24 +: RW];
        b2i    = ir_q[16 +: RW];
        b3i    = ir_q[8 +: RW];
        b4i    = ir_q[0 +: RW];
        imm_w  = DATA_W'(ir_q[23:0]);
        imm_a  = ADDR_W'(ir_q[23:0]);
        pc_inc = pc_q + ADDR_W'(1);
        rf     = '0;
        rb2    = '0;
        rb3    = '0;
        rb4    = '0;
        if (int'(fi)  < NUM_REGS) rf  = regs_q[fi];
        if (int'(b2i) < NUM_REGS) rb2 = regs_q[b2i];
        if (int'(b3i) < NUM_REGS) rb3 = regs_q[b3i];
        if (int'(b4i) < NUM_REGS) rb4 = regs_q[b4i];
    end

    always_comb begin
        opnd = rb4 << sh;
        unique case (arg)
            2'b00:   alu_res = rb3 + opnd;
            2'b01:   alu_res = rb3 - opnd;
            2'b10:   alu_res = rb3 & opnd;
            default: alu_res = rb3 | opnd;
        endcase
        unique case (arg)
            2'b00:   taken = 1'b1;
            2'b01:   taken = z_q;
            2'b10:   taken = ~z_q;
            default: taken = n_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        regs_d   = regs_q;
        z_d      = z_q;
        n_d      = n_q;
        retire_d = 1'b0;
        halted_d = halted_q;
        we_d     = we_q;
        daddr_d  = daddr_q;
        wdata_d  = wdata_q;
        wr_en    = 1'b0;
        wr_idx   = fi;
        wr_val   = rf;

        unique case (state_q)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                retire_d = 1'b1;
                state_d  = S_FETCH;
                pc_d     = pc_inc;
                unique case (op)
                    2'b00: begin
                        unique case (arg)
                            2'b00, 2'b10: begin
                                // Address and store data are frozen here for the whole MEM phase.
                                we_d     = arg[1];
                                daddr_d  = ADDR_W'(rb2);
                                wdata_d  = rf;
                                retire_d = 1'b0;
                                pc_d     = pc_q;
                                state_d  = S_MEM;
                            end
                            2'b01: begin
                                wr_en  = 1'b1;
                                wr_val = imm_w;
                            end
                            default: begin
                                wr_en  = 1'b1;
                                wr_val = rb2;
                            end
                        endcase
                    end
                    2'b01: begin
                        retire_d = 1'b0;
                        halted_d = 1'b1;
                        pc_d     = pc_q;
                        state_d  = S_HALT;
                    end
                    2'b10: begin
                        if (taken) pc_d = sh[0] ? imm_a : ADDR_W'(rb2);
                    end
                    default: begin
                        wr_en  = 1'b1;
                        wr_idx = b2i;
                        wr_val = alu_res;
                        z_d    = (alu_res == '0);
                        n_d    = alu_res[DATA_W-1];
                    end
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    wr_en    = ~we_q;
                    wr_val   = bus.dmem_rdata;
                    pc_d     = pc_inc;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: ;
        endcase

        if (wr_en && (int'(wr_idx) < NUM_REGS)) regs_d[wr_idx] = wr_val;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            regs_q   <= '{default: '0};
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
            we_q     <= 1'b0;
            daddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            regs_q   <= regs_d;
            z_q      <= z_d;
            n_q      <= n_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            we_q     <= we_d;
            daddr_q  <= daddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Fetch request is masked while reset is held so it drops immediately, even mid-handshake.
    assign bus.imem_req   = (state_q == S_FETCH) && reset;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = (state_q == S_MEM);
    assign bus.dmem_we    = we_q && (state_q == S_MEM);
    assign bus.dmem_addr  = daddr_q;
    assign bus.dmem_wdata = wdata_q;
    assign retire         = retire_q;
    assign halted         = halted_q;
endmodule

// File: tb/tb_multicycle_processor.sv
// Scoreboard bench: expected fetch addresses and data transactions are queued up front,
// a monitor pops and compares them whenever a handshake completes.
module tb_multicycle_processor;
    localparam logic [31:0] HALT_W = 32'h4000_0000;
    localparam logic [31:0] BAD_W  = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset_b;
    logic retire, halted, retire_b, halted_b;

    multicycle_processor_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    multicycle_processor_if #(.DATA_W(24), .ADDR_W(8))  bus_b ();

    multicycle_processor #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .retire(retire), .halted(halted));
    multicycle_processor #(.DATA_W(24), .NUM_REGS(4), .ADDR_W(8), .RESET_PC(8'hFF)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b), .retire(retire_b), .halted(halted_b));

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] movi(input logic [3:0] f, input logic [23:0] imm);
        return {4'b0001, f, imm};
    endfunction
    function automatic logic [31:0] st(input logic [3:0] f, input logic [3:0] b2);
        return {4'b0010, f, 4'h0, b2, 16'h0};
    endfunction
    function automatic logic [31:0] ld(input logic [3:0] f, input logic [3:0] b2);
        return {4'b0000, f, 4'h0, b2, 16'h0};
    endfunction
    function automatic logic [31:0] mvr(input logic [3:0] f, input logic [3:0] b2);
        return {4'b0011, f, 4'h0, b2, 16'h0};
    endfunction
    function automatic logic [31:0] jmpi(input logic [1:0] c, input logic [23:0] imm);
        return {2'b10, c, 4'h1, imm};
    endfunction
    function automatic logic [31:0] jmpr(input logic [1:0] c, input logic [3:0] b2);
        return {2'b10, c, 4'h0, 4'h0, b2, 16'h0};
    endfunction
    function automatic logic [31:0] alu(input logic [1:0] o, input logic [3:0] sh,
                                        input logic [3:0] b2, input logic [3:0] b3, input logic [3:0] b4);
        return {2'b11, o, sh, 4'h0, b2, 4'h0, b3, 4'h0, b4};
    endfunction

    logic [31:0] imem_a [256];
    logic [31:0] dmem_a [256];
    logic [31:0] imem_b [256];

    // Scoreboard queues: fetch addresses and {we, addr, wdata} data transactions.
    logic [31:0] fq_a [$];
    logic [31:0] fq_b [$];
    logic [64:0] dq_a [$];
    logic [64:0] dq_b [$];

    bit ien_a = 1'b1;
    bit ien_b = 1'b1;
    int icnt_a = 0;
    int dcnt_a = 0;

    // Memory models: fetch stalls one cycle above 0x40, data stalls three cycles.
    // Outside a request, rdata carries a HALT word / junk and dmem_ack idles high.
    always @(posedge clk) begin
        #1;
        if (bus_a.imem_req && ien_a) begin
            if (icnt_a >= (bus_a.imem_addr[6] ? 1 : 0)) begin
                bus_a.imem_ack   = 1'b1;
                bus_a.imem_rdata = imem_a[bus_a.imem_addr[7:0]];
                icnt_a = 0;
            end else begin
                bus_a.imem_ack   = 1'b0;
                bus_a.imem_rdata = HALT_W;
                icnt_a++;
            end
        end else begin
            bus_a.imem_ack   = !bus_a.imem_req && reset;
            bus_a.imem_rdata = HALT_W;
            icnt_a = 0;
        end
        if (bus_a.dmem_req) begin
            if (dcnt_a >= 3) begin
                bus_a.dmem_ack = 1'b1;
                if (bus_a.dmem_we) dmem_a[bus_a.dmem_addr[7:0]] = bus_a.dmem_wdata;
                bus_a.dmem_rdata = dmem_a[bus_a.dmem_addr[7:0]];
                dcnt_a = 0;
            end else begin
                bus_a.dmem_ack   = 1'b0;
                bus_a.dmem_rdata = BAD_W;
                dcnt_a++;
            end
        end else begin
            bus_a.dmem_ack   = 1'b1;
            bus_a.dmem_rdata = BAD_W;
            dcnt_a = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus_b.imem_req && ien_b && bus_b.imem_addr != 8'h11) begin
            bus_b.imem_ack   = 1'b1;
            bus_b.imem_rdata = imem_b[bus_b.imem_addr];
        end else begin
            bus_b.imem_ack   = !bus_b.imem_req && reset_b;
            bus_b.imem_rdata = HALT_W;
        end
        bus_b.dmem_ack   = 1'b1;
        bus_b.dmem_rdata = 24'hBADBAD;
    end

    int          cyc = 0;
    int          ret_a = 0;
    int          ret_b = 0;
    int          ret_t_a [3];
    bit          d_act_a = 1'b0;
    int          d_len_a = 0;
    bit          d_unstable_a = 1'b0;
    logic [64:0] d_snap_a;

    always @(negedge clk) begin
        logic [64:0] cur, e;
        cyc++;
        if (retire) begin
            if (ret_a < 3) ret_t_a[ret_a] = cyc;
            ret_a++;
        end
        if (retire_b) ret_b++;

        if (reset && bus_a.imem_req && bus_a.imem_ack) begin
            if (fq_a.size() == 0) check("fetch_a_unexpected", 64'(bus_a.imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("fetch_a_addr", 64'(bus_a.imem_addr), 64'(fq_a.pop_front()));
        end
        if (reset_b && bus_b.imem_req && bus_b.imem_ack) begin
            if (fq_b.size() == 0) check("fetch_b_unexpected", 64'(bus_b.imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            else check("fetch_b_addr", 64'(bus_b.imem_addr), 64'(fq_b.pop_front()));
        end

        if (bus_a.dmem_req) begin
            cur = {bus_a.dmem_we, bus_a.dmem_addr, bus_a.dmem_wdata};
            if (!d_act_a) begin
                d_act_a      = 1'b1;
                d_len_a      = 0;
                d_unstable_a = 1'b0;
                d_snap_a     = cur;
            end
            d_len_a++;
            if (cur !== d_snap_a) d_unstable_a = 1'b1;
            if (bus_a.dmem_ack) begin
                d_act_a = 1'b0;
                check("dmem_a_req_cycles", 64'(d_len_a), 64'd4);
                check("dmem_a_stable", 64'(d_unstable_a), 64'd0);
                if (dq_a.size() == 0) check("dmem_a_unexpected", 64'(cur[64:32]), 64'hFFFF_FFFF_FFFF_FFFF);
                else begin
                    e = dq_a.pop_front();
                    check("dmem_a_we_addr", 64'(cur[64:32]), 64'(e[64:32]));
                    if (e[64]) check("dmem_a_wdata", 64'(cur[31:0]), 64'(e[31:0]));
                end
            end
        end

        if (bus_b.dmem_req && bus_b.dmem_ack) begin
            cur = {bus_b.dmem_we, 24'h0, bus_b.dmem_addr, 8'h0, bus_b.dmem_wdata};
            if (dq_b.size() == 0) check("dmem_b_unexpected", 64'(cur[64:32]), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                e = dq_b.pop_front();
                check("dmem_b_we_addr", 64'(cur[64:32]), 64'(e[64:32]));
                check("dmem_b_wdata", 64'(cur[31:0]), 64'(e[31:0]));
            end
        end
    end

    initial begin
        int n;
        int bad;
        reset   = 1'b0;
        reset_b = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem_a[i] = HALT_W;
            imem_b[i] = HALT_W;
            dmem_a[i] = 32'h0;
        end

        // Core A program: immediates, ALU, flag-conditional jumps, store/load, HALT.
        imem_a[8'h00] = movi(4'd1, 24'd5);
        imem_a[8'h01] = movi(4'd2, 24'd7);
        imem_a[8'h02] = alu(2'b00, 4'd0, 4'd3, 4'd1, 4'd2);
        imem_a[8'h03] = movi(4'd5, 24'h20);
        imem_a[8'h04] = st(4'd3, 4'd5);
        imem_a[8'h05] = movi(4'd2, 24'd5);
        imem_a[8'h06] = alu(2'b01, 4'd0, 4'd3, 4'd1, 4'd2);
        imem_a[8'h07] = jmpi(2'b01, 24'h40);
        imem_a[8'h40] = jmpi(2'b10, 24'h80);
        imem_a[8'h41] = movi(4'd4, 24'hDEAD);
        imem_a[8'h42] = movi(4'd5, 24'h10);
        imem_a[8'h43] = st(4'd4, 4'd5);
        imem_a[8'h44] = ld(4'd6, 4'd5);
        imem_a[8'h45] = movi(4'd7, 24'hFFFFFF);
        imem_a[8'h46] = alu(2'b11, 4'd8, 4'd7, 4'd7, 4'd7);
        imem_a[8'h47] = jmpi(2'b11, 24'h70);
        imem_a[8'h70] = movi(4'd8, 24'd1);
        imem_a[8'h71] = jmpi(2'b00, 24'h48);
        imem_a[8'h48] = alu(2'b00, 4'd0, 4'd9, 4'd7, 4'd8);
        imem_a[8'h49] = jmpi(2'b11, 24'h80);
        imem_a[8'h4A] = jmpi(2'b01, 24'h50);
        imem_a[8'h50] = st(4'd6, 4'd11);
        imem_a[8'h51] = st(4'd9, 4'd5);
        imem_a[8'h52] = mvr(4'd12, 4'd7);
        imem_a[8'h53] = st(4'd12, 4'd11);
        imem_a[8'h54] = movi(4'd13, 24'h60);
        imem_a[8'h55] = jmpr(2'b00, 4'd13);
        imem_a[8'h60] = HALT_W;
        for (int a = 0; a <= 7; a++) fq_a.push_back(32'(a));
        for (int a = 'h40; a <= 'h47; a++) fq_a.push_back(32'(a));
        fq_a.push_back(32'h70);
        fq_a.push_back(32'h71);
        for (int a = 'h48; a <= 'h4A; a++) fq_a.push_back(32'(a));
        for (int a = 'h50; a <= 'h55; a++) fq_a.push_back(32'(a));
        fq_a.push_back(32'h60);
        dq_a.push_back({1'b1, 32'h20, 32'd12});
        dq_a.push_back({1'b1, 32'h10, 32'hDEAD});
        dq_a.push_back({1'b0, 32'h10, 32'h0});
        dq_a.push_back({1'b1, 32'h00, 32'hDEAD});
        dq_a.push_back({1'b1, 32'h10, 32'h0});
        dq_a.push_back({1'b1, 32'h00, 32'hFFFF_FFFF});

        // Core B (24-bit data, 4 regs, 8-bit PC): PC wrap, aliased reg field, 24-bit overflow.
        imem_b[8'hFF] = movi(4'hD, 24'h123);
        imem_b[8'h00] = st(4'hD, 4'h2);
        imem_b[8'h01] = movi(4'h2, 24'hFFFFFF);
        imem_b[8'h02] = movi(4'h7, 24'h1);
        imem_b[8'h03] = alu(2'b00, 4'd0, 4'h0, 4'h2, 4'h3);
        imem_b[8'h04] = jmpi(2'b01, 24'h310);
        imem_b[8'h10] = st(4'h0, 4'h1);
        fq_b.push_back(32'hFF);
        for (int a = 0; a <= 4; a++) fq_b.push_back(32'(a));
        fq_b.push_back(32'h10);
        dq_b.push_back({1'b1, 32'h00, 32'h123});
        dq_b.push_back({1'b1, 32'h23, 32'h0});

        repeat (2) @(negedge clk);
        check("reset_a_outputs", {bus_a.imem_req, bus_a.dmem_req, bus_a.dmem_we, retire, halted}, 5'b0);
        check("reset_b_outputs", {bus_b.imem_req, bus_b.dmem_req, bus_b.dmem_we, retire_b, halted_b}, 5'b0);
        reset = 1'b1;

        n = 0;
        while (!halted && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("a_halt_reached", 64'(halted), 64'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_a.imem_req || bus_a.dmem_req || retire) bad++;
        end
        check("a_halt_quiet", 64'(bad), 64'd0);
        check("a_halt_holds", 64'(halted), 64'd1);
        check("a_retire_count", 64'(ret_a), 64'd27);
        check("a_retire_gap0", 64'(ret_t_a[1] - ret_t_a[0]), 64'd2);
        check("a_retire_gap1", 64'(ret_t_a[2] - ret_t_a[1]), 64'd2);
        check("a_fetch_left", 64'(fq_a.size()), 64'd0);
        check("a_dmem_left", 64'(dq_a.size()), 64'd0);

        ien_a = 1'b0;
        reset = 1'b0;
        #1;
        check("a_reset_in_halt", {bus_a.imem_req, bus_a.dmem_req, retire, halted}, 4'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("a_refetch_req", 64'(bus_a.imem_req), 64'd1);
        check("a_refetch_pc", 64'(bus_a.imem_addr), 64'h0);

        @(negedge clk);
        reset_b = 1'b1;
        n = 0;
        while (!(bus_b.imem_req && bus_b.imem_addr == 8'h11) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("b_reached_0x11", 64'(bus_b.imem_req && bus_b.imem_addr == 8'h11), 64'd1);
        repeat (3) @(negedge clk);
        check("b_stall_req_held", {bus_b.imem_req, bus_b.imem_addr}, {1'b1, 8'h11});
        check("b_retire_count", 64'(ret_b), 64'd7);
        check("b_fetch_left", 64'(fq_b.size()), 64'd0);
        check("b_dmem_left", 64'(dq_b.size()), 64'd0);
        ien_b = 1'b0;
        reset_b = 1'b0;
        #1;
        check("b_midfetch_reset_drops_req", 64'(bus_b.imem_req), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        @(posedge clk);
        #2;
        check("b_refetch", {bus_b.imem_req, bus_b.imem_addr}, {1'b1, 8'hFF});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
